cd_weight_update: RTL
=====================

Name: cd_weight_update

Overview:
Reader/consumer end of the RBM outer-product accumulator. After a CD batch, it sweeps every (i,h) entry of the positive and negative accumulator banks. For each entry it computes dW = lr*(pos-neg)/2^batch_shift and read-modify-writes the weight RAM with saturation. Optionally it then pulses the accumulator clears. It sits between the accumulator bank and the weight memory, driven by the training sequencer.

Parameters:
I_TILE, 64, visible units per tile
H_TILE, 64, hidden units per tile
N (localparam), I_TILE*H_TILE, entries; AW = $clog2(N)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin sweep (sampled in IDLE only)
lr  in  16  learning rate, unsigned Q0.16
batch_shift  in  4  log2(batch size), 0..15
clear_acc  in  1  pulse acc_clr after sweep
busy  out  1  high from cycle after start accepted until done
done  out  1  one-cycle pulse at sweep end
sat_count  out  16  saturating count of clamped weights this sweep
acc_rd_en  out  1  accumulator read strobe
acc_addr  out  AW  linear index a = i*H_TILE+h
acc_pos_q  in  32  signed Q7.23, valid 1 cycle after acc_rd_en
acc_neg_q  in  32  signed Q7.23, valid 1 cycle after acc_rd_en
acc_clr  out  1  one-cycle clear pulse (drives clr_pos and clr_neg)
w_rd_en  out  1  weight read strobe (same cycle/addr as acc_rd_en)
w_raddr  out  AW  weight read address
w_rdata  in  16  signed Q3.12, valid 1 cycle after w_rd_en
w_we  out  1  weight write enable
w_waddr  out  AW  weight write address
w_wdata  out  16  signed Q3.12 new weight

Behaviour:
- Reset: state IDLE; busy, done, acc_rd_en, w_rd_en, w_we, acc_clr = 0; addresses = 0; sat_count = 0.
- Start handling: start in IDLE latches lr, batch_shift, clear_acc and clears sat_count. start in any other state is ignored.
- FSM: IDLE -> RUN -> DRAIN -> (CLR if clear_acc) -> FIN -> IDLE.
- RUN: issues reads for a = 0..N-1, one per cycle, in cycles 1..N (start sampled in cycle 0). acc_rd_en = w_rd_en = 1, with acc_addr = w_raddr = a.
- DRAIN: waits for the pipeline to empty (3 cycles).
- CLR: acc_clr = 1 for one cycle.
- FIN: done = 1 for one cycle; busy drops in the same cycle.
- Pipeline: 3 stages, throughput 1 entry/cycle, no stalls.
  - S1 (data-return cycle t+1): diff = pos - neg, 33-bit signed Q8.23; prod = diff * {1'b0,lr}, 50-bit Q9.39 (registered); w_old and addr are registered alongside.
  - S2: delta = (prod >>> batch_shift) >>> 27, arithmetic, truncation toward -inf; sum = w_old + delta at full width; w_wdata = clamp(sum, -32768, 32767). Outputs are registered.
- Write timing: the write for an entry read in cycle t is visible (w_we=1) in cycle t+3.
- Sweep timing: writes occupy cycles 4..N+3. Without clear, done is in cycle N+4. With clear, acc_clr is in N+4 and done in N+5.
- Saturation: sat_count increments (saturating at 0xFFFF) in each write cycle where the clamp engaged.
- Hazards: read and write addresses of in-flight entries are always distinct, so no forwarding is required. The weight RAM must support a simultaneous read on one port and a write on another.
- Reset mid-sweep: returns to IDLE immediately; in-flight writes are discarded. Weights already written stay written, and the accumulators are not cleared.
- lr = 0 gives delta = 0 for every entry; all weights are rewritten unchanged.

Decomposition:
- Shared package rbm_pkg: Q-format widths (ACC_W=32, W_W=16, LR_W=16), the alignment shift constant (27), and the state enum type.
- One sub-module, cd_delta_pipe: the diff/multiply/shift/saturate datapath with valid and address pipelining. The top level holds the FSM, address counter and sat_count.

Test Plan:
- Entry 0: pos=0x00800000, neg=0, lr=0x8000, shift=0, w_old=0 -> w_wdata=0x0800 at cycle 4; sat_count=0.
- pos=0, neg=0x00800000, lr=0x8000, shift=3, w_old=0x0000 -> w_wdata=0xFF00.
- pos=0x00800000, neg=0, lr=0x8000, w_old=0x7F00 -> 0x7FFF, sat_count=1. Mirror case: w_old=0x8100 with negative delta -> 0x8000.
- Truncation: pos=0, neg=1, lr=0x0001, shift=0, w_old=5 -> 4.
- Full sweep, I_TILE=H_TILE=4, random pos/neg/w, clear_acc=1:
  - exactly 16 writes, in address order, at cycles 4..19;
  - every value matches the reference model;
  - acc_clr pulses once at cycle 20 and done once at cycle 21;
  - a start asserted mid-sweep is ignored.
- rst asserted at cycle 8 of a sweep: the next cycle shows all outputs 0, IDLE state and no further w_we. A new start then runs a full sweep correctly.

Source files
------------

// File: rtl/rbm_pkg.sv
// Shared widths, alignment constant and sweep FSM state type for the RBM weight-update path.
package rbm_pkg;
  localparam int unsigned ACC_W       = 32;              // Q7.23 accumulator
  localparam int unsigned W_W         = 16;              // Q3.12 weight
  localparam int unsigned LR_W        = 16;              // Q0.16 learning rate
  localparam int unsigned DIFF_W      = ACC_W + 1;       // Q8.23
  localparam int unsigned PROD_W      = DIFF_W + LR_W + 1; // Q9.39
  localparam int unsigned SUM_W       = PROD_W + 1;
  localparam int unsigned ALIGN_SHIFT = 27;              // Q*.39 -> Q*.12

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StDrain,
    StClr,
    StFin
  } state_e;
endpackage

// File: rtl/cd_weight_update_if.sv
// Accumulator-bank and weight-RAM port bundle seen by the weight-update engine.
interface cd_weight_update_if #(
  parameter int unsigned AW = 12
);
  import rbm_pkg::*;

  logic              acc_rd_en;
  logic [AW-1:0]     acc_addr;
  logic [ACC_W-1:0]  acc_pos_q;
  logic [ACC_W-1:0]  acc_neg_q;
  logic              acc_clr;
  logic              w_rd_en;
  logic [AW-1:0]     w_raddr;
  logic [W_W-1:0]    w_rdata;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [W_W-1:0]    w_wdata;

  modport master (
    output acc_rd_en, acc_addr, acc_clr, w_rd_en, w_raddr, w_we, w_waddr, w_wdata,
    input  acc_pos_q, acc_neg_q, w_rdata
  );

  modport slave (
    input  acc_rd_en, acc_addr, acc_clr, w_rd_en, w_raddr, w_we, w_waddr, w_wdata,
    output acc_pos_q, acc_neg_q, w_rdata
  );
endinterface

// File: rtl/cd_delta_pipe.sv
// dW = lr*(pos-neg)/2^batch_shift datapath: tag, multiply, shift/add/clamp stages.
module cd_delta_pipe
  import rbm_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_valid,
  input  logic [AW-1:0]    rd_addr,
  input  logic [LR_W-1:0]  lr,
  input  logic [3:0]       batch_shift,
  input  logic [ACC_W-1:0] pos,
  input  logic [ACC_W-1:0] neg,
  input  logic [W_W-1:0]   w_old,
  output logic             w_we,
  output logic [AW-1:0]    w_waddr,
  output logic [W_W-1:0]   w_wdata,
  output logic             sat
);
  // Tag of the read whose data returns this cycle.
  logic                     ret_valid_q;
  logic [AW-1:0]            ret_addr_q;
  logic                     s1_valid_q;
  logic [AW-1:0]            s1_addr_q;
  logic signed [PROD_W-1:0] s1_prod_q;
  logic [W_W-1:0]           s1_w_q;
  logic                     we_q;
  logic [AW-1:0]            waddr_q;
  logic [W_W-1:0]           wdata_q;
  logic                     sat_q;

  logic signed [DIFF_W-1:0] diff;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] delta;
  logic signed [SUM_W-1:0]  sum;
  logic [SUM_W-W_W:0]       sum_hi;
  logic [W_W-1:0]           wnew;
  logic                     clamp;

  always_comb begin
    diff  = $signed({pos[ACC_W-1], pos}) - $signed({neg[ACC_W-1], neg});
    prod  = PROD_W'(diff) * PROD_W'($signed({1'b0, lr}));
    delta = (s1_prod_q >>> batch_shift) >>> ALIGN_SHIFT;
    sum   = SUM_W'(delta) + SUM_W'($signed(s1_w_q));
    // Sum fits in W_W bits only when all bits above the weight sign bit agree.
    sum_hi = sum[SUM_W-1:W_W-1];
    clamp  = (sum_hi != '0) && (sum_hi != '1);
    wnew   = sum[W_W-1:0];
    if (clamp) wnew = sum[SUM_W-1] ? 16'h8000 : 16'h7FFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_valid_q <= 1'b0;
      ret_addr_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_prod_q   <= '0;
      s1_w_q      <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      ret_valid_q <= rd_valid;
      ret_addr_q  <= rd_addr;
      s1_valid_q  <= ret_valid_q;
      s1_addr_q   <= ret_addr_q;
      s1_prod_q   <= prod;
      s1_w_q      <= w_old;
      we_q        <= s1_valid_q;
      waddr_q     <= s1_addr_q;
      wdata_q     <= wnew;
      sat_q       <= s1_valid_q & clamp;
    end
  end

  assign w_we    = we_q;
  assign w_waddr = waddr_q;
  assign w_wdata = wdata_q;
  assign sat     = sat_q;
endmodule

// File: rtl/cd_weight_update.sv
// Sweeps every accumulator entry once per CD batch and read-modify-writes the weight RAM.
module cd_weight_update
  import rbm_pkg::*;
#(
  parameter int unsigned I_TILE = 64,
  parameter int unsigned H_TILE = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LR_W-1:0] lr,
  input  logic [3:0]      batch_shift,
  input  logic            clear_acc,
  output logic            busy,
  output logic            done,
  output logic [15:0]     sat_count,
  cd_weight_update_if.master bus
);
  localparam int unsigned N  = I_TILE * H_TILE;
  localparam int unsigned AW = $clog2(N);

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [1:0]      drain_q, drain_d;
  logic [LR_W-1:0] lr_q, lr_d;
  logic [3:0]      shift_q, shift_d;
  logic            clr_q, clr_d;
  logic [15:0]     sat_q, sat_d;

  logic            pipe_we;
  logic [AW-1:0]   pipe_waddr;
  logic [W_W-1:0]  pipe_wdata;
  logic            pipe_sat;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    lr_d    = lr_q;
    shift_d = shift_q;
    clr_d   = clr_q;
    sat_d   = sat_q;
    if (pipe_we && pipe_sat && (sat_q != 16'hFFFF)) sat_d = sat_q + 16'd1;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          addr_d  = '0;
          lr_d    = lr;
          shift_d = batch_shift;
          clr_d   = clear_acc;
          sat_d   = '0;
        end
      end
      StRun: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == AW'(N - 1)) begin
          state_d = StDrain;
          addr_d  = '0;
          drain_d = '0;
        end
      end
      StDrain: begin
        // Three cycles covers the return + two pipeline stages of the last read.
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd2) state_d = clr_q ? StClr : StFin;
      end
      StClr:   state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      drain_q <= '0;
      lr_q    <= '0;
      shift_q <= '0;
      clr_q   <= 1'b0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      lr_q    <= lr_d;
      shift_q <= shift_d;
      clr_q   <= clr_d;
      sat_q   <= sat_d;
    end
  end

  cd_delta_pipe #(
    .AW(AW)
  ) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .rd_valid    (state_q == StRun),
    .rd_addr     (addr_q),
    .lr          (lr_q),
    .batch_shift (shift_q),
    .pos         (bus.acc_pos_q),
    .neg         (bus.acc_neg_q),
    .w_old       (bus.w_rdata),
    .w_we        (pipe_we),
    .w_waddr     (pipe_waddr),
    .w_wdata     (pipe_wdata),
    .sat         (pipe_sat)
  );

  assign busy          = (state_q == StRun) || (state_q == StDrain) || (state_q == StClr);
  assign done          = (state_q == StFin);
  assign sat_count     = sat_q;
  assign bus.acc_rd_en = (state_q == StRun);
  assign bus.w_rd_en   = (state_q == StRun);
  assign bus.acc_addr  = addr_q;
  assign bus.w_raddr   = addr_q;
  assign bus.acc_clr   = (state_q == StClr);
  assign bus.w_we      = pipe_we;
  assign bus.w_waddr   = pipe_waddr;
  assign bus.w_wdata   = pipe_wdata;
endmodule
